mem_port_arbiter: RTL

Shares the single 256-bit physical memory port between the CPU-side MMU line port and a read-only DMA line requester, such as a video scan-out or block-copy engine. It sits between the CPU's external memory interface and the memory controller. It grants one line transaction at a time and gives priority to the DMA port. A bounded-run fairness counter guarantees the CPU forward progress.

---
 rtl/mem_port_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Two-port line arbiter: a read-only DMA requester and the CPU line port share one 256-bit memory port.
// Optional GRANT watchdog is built when MEM_ARB_TIMEOUT_EN is defined.
module mem_port_arbiter #(
  parameter int MAX_DMA_RUN = 4,
  parameter int TIMEOUT     = 1023
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  cpu_addr_i,
  input  logic [255:0] cpu_data_i,
  output logic [255:0] cpu_data_o,
  input  logic         cpu_we_i,
  input  logic         cpu_rd_i,
  output logic         cpu_ack_o,
  input  logic [31:0]  dma_addr_i,
  input  logic         dma_rd_i,
  output logic [255:0] dma_data_o,
  output logic         dma_ack_o,
  output logic [31:0]  mem_addr_o,
  output logic [255:0] mem_data_o,
  input  logic [255:0] mem_data_i,
  output logic         mem_we_o,
  output logic         mem_rd_o,
  input  logic         mem_ack_i,
  output logic         timeout_o
);

  if (MAX_DMA_RUN < 1 || MAX_DMA_RUN > 15) begin : g_bad_run
    $error("MAX_DMA_RUN must be within 1..15");
  end
  if (TIMEOUT < 1 || TIMEOUT > 1023) begin : g_bad_timeout
    $error("TIMEOUT must be within 1..1023");
  end

  localparam logic [3:0] RUN_MAX = 4'(MAX_DMA_RUN);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;
  typedef enum logic {OWN_CPU = 1'b0, OWN_DMA = 1'b1} owner_t;

  state_t     state_reg, state_next;
  owner_t     owner_reg, owner_next;
  logic [3:0] run_reg, run_next;
  logic       cpu_req;
  logic       grant_cpu;
  logic       grant_dma;
  logic       timeout_hit;

  assign cpu_req   = cpu_rd_i | cpu_we_i;
  assign grant_cpu = (state_reg == GRANT) && (owner_reg == OWN_CPU);
  assign grant_dma = (state_reg == GRANT) && (owner_reg == OWN_DMA);

`ifdef MEM_ARB_TIMEOUT_EN
  localparam logic [9:0] TO_LIMIT = 10'(TIMEOUT);
  logic [9:0] to_cnt_reg;

  // Held at zero while idle, so every grant starts counting from zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt_reg <= '0;
    end else if (state_reg == IDLE) begin
      to_cnt_reg <= '0;
    end else if (!mem_ack_i) begin
      to_cnt_reg <= to_cnt_reg + 10'd1;
    end
  end

  assign timeout_hit = (state_reg == GRANT) && !mem_ack_i && (to_cnt_reg == TO_LIMIT);
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      owner_reg <= OWN_CPU;
      run_reg   <= '0;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
      run_reg   <= run_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    run_next   = run_reg;
    case (state_reg)
      IDLE: begin
        // DMA has priority until it has taken RUN_MAX grants in a row over a waiting CPU.
        if (dma_rd_i && !(cpu_req && run_reg == RUN_MAX)) begin
          state_next = GRANT;
          owner_next = OWN_DMA;
          run_next   = cpu_req ? run_reg + 4'd1 : 4'd0;
        end else if (cpu_req) begin
          state_next = GRANT;
          owner_next = OWN_CPU;
          run_next   = 4'd0;
        end
      end
      GRANT: begin
        if (mem_ack_i || timeout_hit) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mem_addr_o = '0;
    mem_data_o = '0;
    mem_we_o   = 1'b0;
    mem_rd_o   = 1'b0;
    cpu_ack_o  = 1'b0;
    cpu_data_o = '0;
    dma_ack_o  = 1'b0;
    dma_data_o = '0;
    if (grant_cpu) begin
      mem_addr_o = cpu_addr_i;
      mem_data_o = cpu_data_i;
      mem_we_o   = cpu_we_i;
      mem_rd_o   = cpu_rd_i;
      cpu_ack_o  = mem_ack_i | timeout_hit;
      cpu_data_o = mem_ack_i ? mem_data_i : '0;
    end else if (grant_dma) begin
      mem_addr_o = dma_addr_i;
      mem_rd_o   = dma_rd_i;
      dma_ack_o  = mem_ack_i | timeout_hit;
      dma_data_o = mem_ack_i ? mem_data_i : '0;
    end
  end

  assign timeout_o = timeout_hit;

endmodule
